// File: rtl/logic_unit_seq_if.sv
// Operand/result handshake bundle for logic_unit_seq.
// The master drives the operands and the result acceptance; the slave is the logic unit.
interface logic_unit_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Registered logic unit: six single-cycle bitwise ops plus iterative rotate-left and
// population count, with valid/ready handshakes on both sides.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  logic_unit_seq_if.slave   bus
);

  // Rotate-amount width; the counter carries one extra bit so it can hold WIDTH.
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [CW:0] CntOne  = (CW + 1)'(1);
  localparam logic [CW:0] CntFull = (CW + 1)'(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : gen_width_check
    $error("logic_unit_seq: WIDTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    OpAnd    = 3'b000,
    OpOr     = 3'b001,
    OpXor    = 3'b010,
    OpNot    = 3'b011,
    OpNand   = 3'b100,
    OpNor    = 3'b101,
    OpRol    = 3'b110,
    OpPopcnt = 3'b111
  } op_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW:0]      cnt_q;
  logic             is_pop_q;

  op_e              op_in;
  logic [CW-1:0]    rot_k;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] acc_rol;
  logic [WIDTH-1:0] pop_bit;

  assign op_in   = op_e'(bus.op);
  assign rot_k   = bus.b[CW-1:0];
  assign acc_rol = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
  assign pop_bit = {{(WIDTH-1){1'b0}}, acc_q[0]};

  // Single-cycle bitwise result for the incoming op; ROL/POPCNT slots are unused here.
  always_comb begin
    simple_res = '0;
    unique case (op_in)
      OpAnd:    simple_res = bus.a & bus.b;
      OpOr:     simple_res = bus.a | bus.b;
      OpXor:    simple_res = bus.a ^ bus.b;
      OpNot:    simple_res = ~bus.a;
      OpNand:   simple_res = ~(bus.a & bus.b);
      OpNor:    simple_res = ~(bus.a | bus.b);
      OpRol:    simple_res = '0;
      OpPopcnt: simple_res = '0;
      default:  simple_res = '0;
    endcase
  end

  // Control FSM and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      is_pop_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (op_in == OpRol) begin
              if (rot_k == '0) begin
                // Rotate by a multiple of WIDTH is the identity; skip RUN entirely.
                result_q <= bus.a;
                state_q  <= StDone;
              end else begin
                acc_q    <= bus.a;
                cnt_q    <= {1'b0, rot_k};
                is_pop_q <= 1'b0;
                state_q  <= StRun;
              end
            end else if (op_in == OpPopcnt) begin
              acc_q    <= bus.a;
              result_q <= '0;
              cnt_q    <= CntFull;
              is_pop_q <= 1'b1;
              state_q  <= StRun;
            end else begin
              result_q <= simple_res;
              state_q  <= StDone;
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q - CntOne;
          if (is_pop_q) begin
            result_q <= result_q + pop_bit;
            acc_q    <= acc_q >> 1;
          end else begin
            acc_q <= acc_rol;
          end
          if (cnt_q == CntOne) begin
            if (!is_pop_q) begin
              result_q <= acc_rol;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StRun);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);

endmodule
